// File: rtl/video_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one Avalon-ST RGB565 video input between two sources.
// Grants a source from SOP to EOP, passes the beat path combinationally and checks frame length.
module video_frame_arbiter #(
    parameter int unsigned FRAME_PIXELS = 76800,
    parameter int unsigned CNT_W        = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        valid_in0,
    input  logic [15:0] data_in0,
    input  logic        sop_in0,
    input  logic        eop_in0,
    input  logic        valid_in1,
    input  logic [15:0] data_in1,
    input  logic        sop_in1,
    input  logic        eop_in1,
    output logic        ready_out0,
    output logic        ready_out1,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [15:0] data_out,
    output logic        sop_out,
    output logic        eop_out,
    output logic [1:0]  grant,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] drop_count
);

    localparam logic [CNT_W-1:0] FrameCnt = FRAME_PIXELS[CNT_W-1:0];
    localparam logic [CNT_W:0]   FrameLen = {1'b0, FrameCnt};
    localparam logic [CNT_W:0]   CntOne   = 1;

    typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;

    logic              drop0, drop1, req0, req1;
    logic              g_valid, g_sop, g_eop, xfer;
    logic [CNT_W:0]    cnt_inc;
    logic [16:0]       drop_sum;

    assign drop0   = valid_in0 & ~sop_in0;
    assign drop1   = valid_in1 & ~sop_in1;
    assign req0    = enable & valid_in0 & sop_in0;
    assign req1    = enable & valid_in1 & sop_in1;
    assign g_valid = (state_q == StG1) ? valid_in1 : valid_in0;
    assign g_sop   = (state_q == StG1) ? sop_in1 : sop_in0;
    assign g_eop   = (state_q == StG1) ? eop_in1 : eop_in0;
    assign xfer    = g_valid & ready_in;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            pix_cnt_q    <= '0;
            drop_count_q <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pix_cnt_q    <= pix_cnt_d;
            drop_count_q <= drop_count_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pix_cnt_d    = pix_cnt_q;
        drop_count_d = drop_count_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        cnt_inc      = {1'b0, pix_cnt_q} + CntOne;
        drop_sum     = {1'b0, drop_count_q} + {16'b0, drop0} + {16'b0, drop1};
        unique case (state_q)
            StIdle: begin
                drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                pix_cnt_d    = '0;
                // On a tie the source that did not own the last frame wins.
                if (req0 && req1) begin
                    state_d = last_grant_q ? StG0 : StG1;
                end else if (req0) begin
                    state_d = StG0;
                end else if (req1) begin
                    state_d = StG1;
                end
            end
            StG0, StG1: begin
                if (xfer) begin
                    if (g_sop && (pix_cnt_q != '0)) begin
                        frame_err_d = 1'b1;
                        pix_cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        // Counter parks at the frame length so overrun is reported once.
                        if (pix_cnt_q != FrameCnt) begin
                            pix_cnt_d = cnt_inc[CNT_W-1:0];
                        end
                        if (!g_eop && (cnt_inc == FrameLen)) begin
                            frame_err_d = 1'b1;
                        end
                    end
                    if (g_eop) begin
                        state_d      = StIdle;
                        last_grant_d = (state_q == StG1);
                        frame_done_d = 1'b1;
                        if (cnt_inc != FrameLen) begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        valid_out  = 1'b0;
        data_out   = 16'h0;
        sop_out    = 1'b0;
        eop_out    = 1'b0;
        ready_out0 = 1'b0;
        ready_out1 = 1'b0;
        grant      = 2'b00;
        unique case (state_q)
            StIdle: begin
                ready_out0 = drop0;
                ready_out1 = drop1;
            end
            StG0: begin
                valid_out  = valid_in0;
                data_out   = data_in0;
                sop_out    = sop_in0;
                eop_out    = eop_in0;
                ready_out0 = ready_in;
                grant      = 2'b01;
            end
            StG1: begin
                valid_out  = valid_in1;
                data_out   = data_in1;
                sop_out    = sop_in1;
                eop_out    = eop_in1;
                ready_out1 = ready_in;
                grant      = 2'b10;
            end
            default: ;
        endcase
    end

    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_video_frame_arbiter.sv
// Bench for video_frame_arbiter: directed table, corner-case sequences and random stimulus,
// every cycle compared against a frame-level reference model.
module tb_video_frame_arbiter;

    localparam int unsigned FP = 4;
    localparam int unsigned CW = 3;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        rdy;
        logic        v0;
        logic        s0;
        logic        e0;
        logic [15:0] d0;
        logic        v1;
        logic        s1;
        logic        e1;
        logic [15:0] d1;
    } in_t;

    typedef struct {
        in_t         in;
        logic [1:0]  g;
        logic        vo;
        logic [15:0] dout;
        logic        so;
        logic        eo;
        logic        r0;
        logic        r1;
        logic        done;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t         cur;
    logic        ready_out0, ready_out1, valid_out, sop_out, eop_out, frame_done, frame_err;
    logic [15:0] data_out, drop_count;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    // Reference model state: owner -1 means idle; beats is the unsaturated beat count.
    int m_owner = -1;
    int m_last  = 1;
    int m_beats = 0;
    int m_drops = 0;
    bit m_done  = 1'b0;
    bit m_err   = 1'b0;

    video_frame_arbiter #(
        .FRAME_PIXELS(FP),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (cur.rst_n),
        .enable    (cur.en),
        .valid_in0 (cur.v0),
        .data_in0  (cur.d0),
        .sop_in0   (cur.s0),
        .eop_in0   (cur.e0),
        .valid_in1 (cur.v1),
        .data_in1  (cur.d1),
        .sop_in1   (cur.s1),
        .eop_in1   (cur.e1),
        .ready_out0(ready_out0),
        .ready_out1(ready_out1),
        .ready_in  (cur.rdy),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .grant     (grant),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .drop_count(drop_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model, mid-cycle away from the clock edge.
    task automatic sample();
        logic [1:0]  eg;
        logic        ev, es, ee, er0, er1;
        logic [15:0] ed;
        @(negedge clk);
        #2;
        if (m_owner < 0) begin
            eg = 2'b00; ev = 1'b0; es = 1'b0; ee = 1'b0; ed = 16'h0;
            er0 = cur.v0 && !cur.s0;
            er1 = cur.v1 && !cur.s1;
        end else if (m_owner == 0) begin
            eg = 2'b01; ev = cur.v0; es = cur.s0; ee = cur.e0; ed = cur.d0;
            er0 = cur.rdy; er1 = 1'b0;
        end else begin
            eg = 2'b10; ev = cur.v1; es = cur.s1; ee = cur.e1; ed = cur.d1;
            er0 = 1'b0; er1 = cur.rdy;
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("valid_out", 32'(valid_out), 32'(ev));
        chk("data_out", 32'(data_out), 32'(ed));
        chk("sop_out", 32'(sop_out), 32'(es));
        chk("eop_out", 32'(eop_out), 32'(ee));
        chk("ready_out0", 32'(ready_out0), 32'(er0));
        chk("ready_out1", 32'(ready_out1), 32'(er1));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    // Advance one clock and apply the frame rules to the model.
    task automatic tick();
        int b0;
        int nd;
        bit r0, r1, v, s, e;
        @(posedge clk);
        if (!cur.rst_n) begin
            m_owner = -1; m_last = 1; m_beats = 0; m_drops = 0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_owner < 0) begin
                nd = int'(cur.v0 && !cur.s0) + int'(cur.v1 && !cur.s1);
                m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
                r0 = cur.en && cur.v0 && cur.s0;
                r1 = cur.en && cur.v1 && cur.s1;
                if (r0 && r1) m_owner = 1 - m_last;
                else if (r0) m_owner = 0;
                else if (r1) m_owner = 1;
                m_beats = 0;
            end else begin
                v = (m_owner == 1) ? cur.v1 : cur.v0;
                s = (m_owner == 1) ? cur.s1 : cur.s0;
                e = (m_owner == 1) ? cur.e1 : cur.e0;
                if (v && cur.rdy) begin
                    b0 = m_beats;
                    if (s && b0 > 0) begin
                        m_err = 1'b1;
                        m_beats = 1;
                    end else begin
                        m_beats = b0 + 1;
                        if (!e && m_beats == FP) m_err = 1'b1;
                    end
                    if (e) begin
                        m_done = 1'b1;
                        if (b0 + 1 != FP) m_err = 1'b1;
                        m_last = m_owner;
                        m_owner = -1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic set(input int src, input logic v, input logic s, input logic e,
                       input logic [15:0] d);
        if (src == 0) begin
            cur.v0 = v; cur.s0 = s; cur.e0 = e; cur.d0 = d;
        end else begin
            cur.v1 = v; cur.s1 = s; cur.e1 = e; cur.d1 = d;
        end
    endtask

    task automatic do_reset();
        cur = '{default: '0};
        cur.en = 1'b1;
        cur.rdy = 1'b1;
        tick();
        cur.rst_n = 1'b1;
    endtask

    // Wait (bounded) for the DUT to grant src; the caller already presents its SOP beat.
    task automatic arb(input int src);
        int k;
        logic [1:0] oh;
        k = 0;
        oh = (src == 0) ? 2'b01 : 2'b10;
        while (grant !== oh && k < 8) begin
            sample();
            tick();
            k++;
        end
        chk("arb_grant", 32'(grant), 32'(oh));
    endtask

    task automatic beats(input int src, input int n, input logic [15:0] base);
        for (int b = 0; b < n; b++) begin
            set(src, 1'b1, b == 0, b == n - 1, 16'(base + 16'(b)));
            sample();
            tick();
        end
        set(src, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic frame(input int src, input int n, input logic [15:0] base);
        set(src, 1'b1, 1'b1, n == 1, base);
        arb(src);
        beats(src, n, base);
    endtask

    function automatic in_t mk(input logic v, input logic s, input logic e, input logic [15:0] d);
        in_t r;
        r = '{default: '0};
        r.rst_n = 1'b1; r.en = 1'b1; r.rdy = 1'b1;
        r.v0 = v; r.s0 = s; r.e0 = e; r.d0 = d;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        bit   pat[6];
        int   b;

        tbl[0] = '{mk(1, 1, 0, 16'hA001), 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{mk(1, 1, 0, 16'hA001), 2'b01, 1'b1, 16'hA001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{mk(1, 0, 0, 16'hA002), 2'b01, 1'b1, 16'hA002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{mk(1, 0, 0, 16'hA003), 2'b01, 1'b1, 16'hA003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{mk(1, 0, 1, 16'hA004), 2'b01, 1'b1, 16'hA004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{mk(0, 0, 0, 16'h0000), 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{mk(0, 0, 0, 16'h0000), 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{mk(1, 0, 0, 16'hBEEF), 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        do_reset();
        sample();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_drop", 32'(drop_count), 32'h0);
        tick();

        // Directed 4-beat frame on source 0
        for (int i = 0; i < 8; i++) begin
            cur = tbl[i].in;
            sample();
            chk("tbl_grant", 32'(grant), 32'(tbl[i].g));
            chk("tbl_valid", 32'(valid_out), 32'(tbl[i].vo));
            chk("tbl_data", 32'(data_out), 32'(tbl[i].dout));
            chk("tbl_sop", 32'(sop_out), 32'(tbl[i].so));
            chk("tbl_eop", 32'(eop_out), 32'(tbl[i].eo));
            chk("tbl_ready0", 32'(ready_out0), 32'(tbl[i].r0));
            chk("tbl_ready1", 32'(ready_out1), 32'(tbl[i].r1));
            chk("tbl_done", 32'(frame_done), 32'(tbl[i].done));
            chk("tbl_err", 32'(frame_err), 32'(tbl[i].err));
            tick();
        end

        // Simultaneous SOPs alternate 0, 1, 0
        do_reset();
        set(0, 1'b1, 1'b1, 1'b0, 16'h0100);
        set(1, 1'b1, 1'b1, 1'b0, 16'h0200);
        sample();
        tick();
        chk("tie1_grant", 32'(grant), 32'h1);
        beats(0, 4, 16'h0100);
        arb(1);
        beats(1, 4, 16'h0200);
        set(0, 1'b1, 1'b1, 1'b0, 16'h0300);
        set(1, 1'b1, 1'b1, 1'b0, 16'h0400);
        sample();
        tick();
        chk("tie3_grant", 32'(grant), 32'h1);
        set(1, 1'b0, 1'b0, 1'b0, 16'h0);
        beats(0, 4, 16'h0300);

        // Junk beats before SOP are dropped
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set(1, 1'b1, 1'b0, 1'b0, 16'(16'h0BAD + 16'(i)));
            sample();
            chk("junk_valid_out", 32'(valid_out), 32'h0);
            tick();
        end
        set(1, 1'b0, 1'b0, 1'b0, 16'h0);
        sample();
        chk("junk_drops", 32'(drop_count), 32'd3);
        tick();
        frame(1, 4, 16'h1100);

        // Short frame: done and err together
        frame(0, 3, 16'h3000);
        sample();
        chk("short_done", 32'(frame_done), 32'h1);
        chk("short_err", 32'(frame_err), 32'h1);
        tick();

        // Long frame: overrun error after beat 4, length error with done at EOP
        set(0, 1'b1, 1'b1, 1'b0, 16'h6000);
        arb(0);
        for (int i = 0; i < 6; i++) begin
            set(0, 1'b1, i == 0, i == 5, 16'(16'h6000 + 16'(i)));
            sample();
            if (i == 4) chk("long_err_beat4", 32'(frame_err), 32'h1);
            if (i == 5) chk("long_err_once", 32'(frame_err), 32'h0);
            tick();
        end
        set(0, 1'b0, 1'b0, 1'b0, 16'h0);
        sample();
        chk("long_done", 32'(frame_done), 32'h1);
        tick();

        // Backpressure 1,0,0,1: data held, other source blocked
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        set(0, 1'b1, 1'b1, 1'b0, 16'hC000);
        arb(0);
        set(1, 1'b1, 1'b0, 1'b0, 16'hDEAD);
        b = 0;
        for (int i = 0; i < 6; i++) begin
            cur.rdy = pat[i];
            set(0, 1'b1, b == 0, b == 3, 16'(16'hC000 + 16'(b)));
            sample();
            chk("bp_ready0", 32'(ready_out0), 32'(pat[i]));
            chk("bp_ready1", 32'(ready_out1), 32'h0);
            chk("bp_data", 32'(data_out), 32'(16'hC000 + 16'(b)));
            tick();
            if (pat[i]) b++;
        end
        set(0, 1'b0, 1'b0, 1'b0, 16'h0);
        set(1, 1'b0, 1'b0, 1'b0, 16'h0);
        cur.rdy = 1'b1;
        sample();
        chk("bp_done", 32'(frame_done), 32'h1);
        chk("bp_err", 32'(frame_err), 32'h0);
        tick();

        // enable low mid-frame: frame completes, pending SOP waits
        do_reset();
        set(0, 1'b1, 1'b1, 1'b0, 16'hD000);
        arb(0);
        cur.en = 1'b0;
        set(1, 1'b1, 1'b1, 1'b0, 16'hE000);
        beats(0, 4, 16'hD000);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("en_hold_grant", 32'(grant), 32'h0);
            tick();
        end
        cur.en = 1'b1;
        sample();
        tick();
        chk("en_regrant", 32'(grant), 32'h2);
        beats(1, 4, 16'hE000);

        // Reset mid-frame aborts with no status pulses
        set(0, 1'b1, 1'b1, 1'b0, 16'hF000);
        arb(0);
        beats(0, 2, 16'hF000);
        cur.rst_n = 1'b0;
        sample();
        tick();
        cur.rst_n = 1'b1;
        sample();
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_valid", 32'(valid_out), 32'h0);
        chk("mid_rst_done", 32'(frame_done), 32'h0);
        chk("mid_rst_err", 32'(frame_err), 32'h0);
        tick();

        // Drop counter saturation with double drops
        do_reset();
        set(0, 1'b1, 1'b0, 1'b0, 16'h0001);
        set(1, 1'b1, 1'b0, 1'b0, 16'h0002);
        for (int i = 0; i < 32770; i++) begin
            sample();
            tick();
        end
        sample();
        chk("drop_sat", 32'(drop_count), 32'hFFFF);
        tick();

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cur.rst_n = ($urandom_range(0, 299) != 0);
            cur.en    = ($urandom_range(0, 9) != 0);
            cur.rdy   = ($urandom_range(0, 3) != 0);
            cur.v0    = ($urandom_range(0, 2) != 0);
            cur.s0    = ($urandom_range(0, 4) == 0);
            cur.e0    = ($urandom_range(0, 3) == 0);
            cur.d0    = 16'($urandom);
            cur.v1    = ($urandom_range(0, 2) != 0);
            cur.s1    = ($urandom_range(0, 4) == 0);
            cur.e1    = ($urandom_range(0, 3) == 0);
            cur.d1    = 16'($urandom);
            sample();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_frame_arbiter.md
# video_frame_arbiter

Frame-level arbiter that shares the single Avalon-ST video pipeline input between two RGB565 pixel sources, e.g. camera DMA and test-pattern generator. It grants one source for a whole frame (startofpacket to endofpacket) and switches only at frame boundaries, round-robin. It passes ready, valid, data and packet markers with zero latency, validates frame length and reports status to the control registers.

## Interface
- FRAME_PIXELS, 76800, expected transfers per frame (320x240); bench overrides to 4
- CNT_W, 17, pixel counter width; must satisfy 2^CNT_W > FRAME_PIXELS
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  allow new grants; 0 lets the current frame finish, then holds IDLE
- valid_in0 / valid_in1  in  1  source valid
- data_in0 / data_in1  in  16  RGB565 pixel
- sop_in0 / sop_in1, eop_in0 / eop_in1  in  1  packet markers
- ready_out0 / ready_out1  out  1  ready to each source
- ready_in  in  1  ready from downstream sink interface
- valid_out  out  1  valid to downstream
- data_out  out  16  muxed pixel
- sop_out, eop_out  out  1  muxed markers
- grant  out  2  one-hot current owner, 00 in IDLE
- frame_done  out  1  one-cycle pulse after each completed frame
- frame_err  out  1  one-cycle pulse on a malformed frame
- drop_count  out  16  saturating count of discarded pre-SOP beats

## Operation
- States: IDLE, G0, G1. Register last_grant (1 bit) holds the most recently granted source.
- Transfer on source i: valid_in_i && ready_out_i. Transfer downstream: valid_out && ready_in.
- IDLE:
  - valid_out=0, sop_out=0, eop_out=0, data_out=0.
  - For each i, if valid_in_i && !sop_in_i, then ready_out_i=1: the beat is discarded and drop_count increments, saturating at 0xFFFF. Two simultaneous drops count +2, still saturating.
  - If enable and source i has valid_in_i && sop_in_i, move to Gi next cycle. If both qualify, pick the source != last_grant. The SOP beat is not consumed in IDLE (ready_out_i=0); it is transferred in Gi.
- Gi:
  - valid_out=valid_in_i, data_out=data_in_i, sop_out=sop_in_i, eop_out=eop_in_i, ready_out_i=ready_in. The other source's ready=0 (no drops while granted).
  - pix_cnt is cleared on grant and increments per transfer.
  - Transfer with eop: return to IDLE, last_grant<=i, frame_done=1. If pix_cnt+1 != FRAME_PIXELS, also frame_err=1.
  - Transfer with sop after the first beat: frame_err=1, pix_cnt restarts at 1, stay in Gi.
  - pix_cnt reaching FRAME_PIXELS without eop: frame_err=1 once. Stay granted until eop; pix_cnt saturates.
- enable dropping mid-frame has no effect until eop.

## Timing
- Reset (reset_n=0 at clk edge): state=IDLE, last_grant=1 (first tie goes to source 0), pix_cnt=0, drop_count=0, grant=00, frame_done=0, frame_err=0, all ready_out=0, valid_out=0.
- Data path is combinational: zero-cycle latency from source to downstream in Gi; ready path is combinational from ready_in.
- Arbitration costs 1 cycle: SOP seen in IDLE at cycle n gives grant at n+1. EOP transfer at cycle m gives IDLE at m+1, so a new frame is earliest granted at m+2.
- frame_done and frame_err are registered pulses asserted the cycle after the triggering transfer.
- A stalled source (valid=0) or stalled sink (ready_in=0) holds state and counter indefinitely.
- Reset mid-frame aborts the frame; there is no frame_done and no frame_err.

## Test plan
- FRAME_PIXELS=4; source 0 sends a 4-beat frame (sop on beat 1, eop on beat 4) with ready_in=1 -> grant=01 one cycle after SOP, 4 beats out unchanged, frame_done pulse, frame_err=0, grant=00.
- Both sources present SOP in the same cycle after reset -> source 0 granted first; after its eop, source 1 granted; third tie -> source 0.
- Source 1 sends 3 junk beats without sop while IDLE -> drop_count=3, valid_out=0 throughout, then its SOP frame is granted normally.
- Granted frame of 3 beats with eop -> frame_done and frame_err pulse together. Frame of 6 beats -> frame_err pulse after beat 4, frame_done after beat 6.
- ready_in toggles 1,0,0,1 during a frame -> ready_out0 mirrors it, data is held, pix_cnt advances only on transfers, the other source sees ready=0.
- enable=0 asserted mid-frame -> frame completes; pending SOP on source 1 not granted until enable=1. Reset_n pulsed mid-frame -> grant=00 and all outputs at reset values next cycle.
